// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared types and helpers for the FFT datapath blocks.
//   DATA_WIDTH : default bits per real/imag component (two's complement)
//   cplx_t     : packed complex sample {re, im}
//   rd_state_t : reorder read-side FSM encoding
//   bitrev     : reverse the low nbits of an index (bits above nbits return 0)
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r_res;
    r_res = '0;
    for (int i = 0; i < nbits; i++) begin
      r_res[i] = idx[nbits-1-i];
    end
    return r_res;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// -----------------------------------------------------------------------------
// fft_reorder_ram
//   Simple dual-port RAM backing the ping-pong frame buffer of the reorder
//   block. One write port, one registered read port (1-cycle latency).
//   Storage is not reset. The address MSB selects the bank.
//   Ports:
//     clk        : clock, all logic on posedge
//     i_wr_en    : write strobe
//     i_wr_addr  : write address {bank, index}
//     i_wr_data  : write data
//     i_rd_en    : read strobe; o_rd_data updates only when set
//     i_rd_addr  : read address {bank, index}
//     o_rd_data  : registered read data
// -----------------------------------------------------------------------------
module fft_reorder_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//   Buffers frames arriving in bit-reversed bin order into a two-bank
//   ping-pong RAM and re-emits each frame in natural order 0..FFT_SIZE-1.
//   Streaming, no backpressure, one sample per clock in and out.
//   Bin 0 of a frame appears on dout two clocks after its last input sample.
//
//   Ports:
//     clk        : clock, all logic on posedge
//     rst        : asynchronous active-high reset
//     din_re/im  : input sample, bit-reversed order
//     din_valid  : qualifies din_*, gaps allowed
//     dout_re/im : output sample, natural order (holds when not valid)
//     dout_valid : qualifies dout_*
//     dout_sof   : bin 0 marker      (only with FFT_REORDER_SOF_EN)
//     dout_eof   : last bin marker   (only with FFT_REORDER_SOF_EN)
//
//   Build option: define FFT_REORDER_SOF_EN to add dout_sof/dout_eof.
//
//   Read FSM:
//     state   | meaning
//     RD_IDLE | no complete bank pending, nothing issued
//     RD_READ | issuing natural-order reads of r_rd_bank, one per clock
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FFT_SIZE   = 1024,
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH-1:0] din_im,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0] dout_im,
  output logic                  dout_valid
`ifdef FFT_REORDER_SOF_EN
  ,
  output logic                  dout_sof,
  output logic                  dout_eof
`endif
);

  localparam int            AW       = $clog2(FFT_SIZE);
  localparam int            SW       = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);

  // write side
  logic [AW-1:0] r_wr_cnt;
  logic          r_wr_bank;
  logic [1:0]    r_bank_full;
  logic          w_wr_done;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;
  logic [AW:0]   w_wr_addr;
  logic [SW-1:0] w_wr_data;

  // read side
  rd_state_t     r_state;
  rd_state_t     w_state_nxt;
  logic          r_rd_bank;
  logic          w_rd_bank_nxt;
  logic [AW-1:0] r_rd_cnt;
  logic          w_rd_done;
  logic          w_other_bank;
  logic          w_issue;
  logic [AW:0]   w_rd_addr;
  logic [SW-1:0] w_rd_data;

  // output pipeline: r_rd_vld aligns with RAM output, r_dout_* with dout
  logic                  r_rd_vld;
  logic                  r_dout_valid;
  logic [DATA_WIDTH-1:0] r_dout_re;
  logic [DATA_WIDTH-1:0] r_dout_im;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign w_wr_done = din_valid && (r_wr_cnt == LAST_IDX);
  assign w_wr_addr = {r_wr_bank, AW'(bitrev(32'(r_wr_cnt), AW))};
  assign w_wr_data = {din_re, din_im};

  assign w_full_set[0] = w_wr_done && !r_wr_bank;
  assign w_full_set[1] = w_wr_done &&  r_wr_bank;
  assign w_full_clr[0] = w_rd_done && !r_rd_bank;
  assign w_full_clr[1] = w_rd_done &&  r_rd_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
    end else begin
      if (din_valid) begin
        r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + AW'(1);
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
      // completion and read finish always hit different banks
      r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      // power-of-2 size: the counter wraps to 0 on its own at the frame end
      r_rd_cnt  <= (r_state == RD_READ) ? r_rd_cnt + AW'(1) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next state
  // A bank completing this cycle is started immediately so bin 0 reaches
  // dout two clocks after the last input sample.
  // ---------------------------------------------------------------------------
  assign w_rd_done    = (r_state == RD_READ) && (r_rd_cnt == LAST_IDX);
  assign w_other_bank = ~r_rd_bank;

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    case (r_state)
      RD_IDLE: begin
        if (|r_bank_full) begin
          w_state_nxt = RD_READ;
          // with both banks full the writer has wrapped back to the older one
          w_rd_bank_nxt = (&r_bank_full) ? r_wr_bank : r_bank_full[1];
        end else if (w_wr_done) begin
          w_state_nxt   = RD_READ;
          w_rd_bank_nxt = r_wr_bank;
        end
      end
      RD_READ: begin
        if (w_rd_done) begin
          if (r_bank_full[w_other_bank] || w_full_set[w_other_bank]) begin
            w_state_nxt   = RD_READ;
            w_rd_bank_nxt = w_other_bank;
          end else begin
            w_state_nxt = RD_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = RD_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_issue   = (r_state == RD_READ);
    w_rd_addr = {r_rd_bank, r_rd_cnt};
  end

  fft_reorder_ram #(
    .ADDR_WIDTH (AW + 1),
    .DATA_WIDTH (SW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (din_valid),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld     <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
    end else begin
      r_rd_vld     <= w_issue;
      r_dout_valid <= r_rd_vld;
      if (r_rd_vld) begin
        r_dout_re <= w_rd_data[SW-1:DATA_WIDTH];
        r_dout_im <= w_rd_data[DATA_WIDTH-1:0];
      end
    end
  end

  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;
  assign dout_valid = r_dout_valid;

`ifdef FFT_REORDER_SOF_EN
  logic r_sof_p;
  logic r_eof_p;
  logic r_dout_sof;
  logic r_dout_eof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sof_p    <= 1'b0;
      r_eof_p    <= 1'b0;
      r_dout_sof <= 1'b0;
      r_dout_eof <= 1'b0;
    end else begin
      r_sof_p    <= w_issue && (r_rd_cnt == '0);
      r_eof_p    <= w_issue && (r_rd_cnt == LAST_IDX);
      r_dout_sof <= r_sof_p;
      r_dout_eof <= r_eof_p;
    end
  end

  assign dout_sof = r_dout_sof;
  assign dout_eof = r_dout_eof;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int N = 8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_re;
  logic [W-1:0] din_im;
  logic         din_valid;
  logic [W-1:0] dout_re;
  logic [W-1:0] dout_im;
  logic         dout_valid;
`ifdef FFT_REORDER_SOF_EN
  logic         dout_sof;
  logic         dout_eof;
`endif

  fft_bitrev_reorder #(
    .FFT_SIZE   (N),
    .DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid)
`ifdef FFT_REORDER_SOF_EN
    ,
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int overruns = 0;
  int cyc      = 0;
  int t_last   = 0;

  // bit-reversed position k of an 8-point frame carries natural bin br[k]
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  int                  q_cyc [$];
  logic signed [W-1:0] q_re  [$];
  logic signed [W-1:0] q_im  [$];
  logic                q_sof [$];
  logic                q_eof [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      q_cyc.push_back(cyc);
      q_re.push_back(dout_re);
      q_im.push_back(dout_im);
`ifdef FFT_REORDER_SOF_EN
      q_sof.push_back(dout_sof);
      q_eof.push_back(dout_eof);
`else
      q_sof.push_back(1'b0);
      q_eof.push_back(1'b0);
`endif
    end
  end

  // a write must never land in a bank still waiting to be read
  always @(posedge clk) begin
    if (!rst && din_valid && dut.r_bank_full[dut.r_wr_bank]) begin
      overruns++;
      $display("FAIL overrun: write into full bank at cycle %0d", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_cyc.delete();
    q_re.delete();
    q_im.delete();
    q_sof.delete();
    q_eof.delete();
  endtask

  // present one input word; it is captured at the next rising edge
  task automatic drive(input int re, input int im, input logic v);
    @(negedge clk);
    din_re    = W'(re);
    din_im    = W'(im);
    din_valid = v;
    if (v) t_last = cyc + 1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    din_valid = 1'b0;
    din_re    = 16'h5a5a;
    din_im    = 16'ha5a5;
    repeat (n) @(negedge clk);
  endtask

  // compare collected output against bins base..base+cnt-1, im = -re
  task automatic check_frames(input string name, input int base, input int cnt, input int t0);
    int n;
    logic signed [W-1:0] exp_re;
    logic signed [W-1:0] exp_im;
    n = q_re.size();
    checks++;
    if (n !== cnt) begin
      failures++;
      $display("FAIL %s count: got %0d expected %0d", name, n, cnt);
    end
    if (n > 0) begin
      checks++;
      if (q_cyc[0] !== t0 + 2) begin
        failures++;
        $display("FAIL %s latency: bin0 at cycle %0d expected %0d", name, q_cyc[0], t0 + 2);
      end
    end
    for (int i = 0; i < n && i < cnt; i++) begin
      exp_re = W'(base + i);
      exp_im = W'(-(base + i));
      checks++;
      if (q_re[i] !== exp_re || q_im[i] !== exp_im) begin
        failures++;
        $display("FAIL %s bin%0d: got re=%0d im=%0d expected re=%0d im=%0d",
                 name, i, q_re[i], q_im[i], exp_re, exp_im);
      end
      checks++;
      if (q_cyc[i] !== q_cyc[0] + i) begin
        failures++;
        $display("FAIL %s contiguity bin%0d: got cycle %0d expected %0d",
                 name, i, q_cyc[i], q_cyc[0] + i);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    din_re    = '0;
    din_im    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || dout_re !== '0 || dout_im !== '0) begin
      failures++;
      $display("FAIL reset outputs: got valid=%0b re=%0d im=%0d expected 0 0 0",
               dout_valid, dout_re, dout_im);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    clear_mon();
    for (int k = 0; k < N; k++) drive(br[k], -br[k], 1'b1);
    idle(14);
    check_frames("single", 0, N, t_last);
    // outputs hold the last bin once the frame is done
    checks++;
    if (dout_valid !== 1'b0 || dout_re !== 16'd7 || dout_im !== 16'hfff9) begin
      failures++;
      $display("FAIL hold: got valid=%0b re=%0d im=%0d expected 0 7 -7",
               dout_valid, dout_re, $signed(dout_im));
    end
  endtask

  task automatic test_gapped();
    clear_mon();
    for (int k = 0; k < N; k++) begin
      drive(br[k], -br[k], 1'b1);
      drive(1234, 4321, 1'b0);
    end
    idle(14);
    check_frames("gapped", 0, N, t_last);
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_mon();
    t0 = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) drive(8 * f + br[k], -(8 * f + br[k]), 1'b1);
      if (f == 0) t0 = t_last;
    end
    idle(30);
    check_frames("b2b", 0, 3 * N, t0);
    checks++;
    if (overruns !== 0) begin
      failures++;
      $display("FAIL b2b overrun count: got %0d expected 0", overruns);
    end
`ifdef FFT_REORDER_SOF_EN
    for (int i = 0; i < q_re.size(); i++) begin
      checks++;
      if (q_sof[i] !== (i % N == 0) || q_eof[i] !== (i % N == N - 1)) begin
        failures++;
        $display("FAIL sof_eof bin%0d: got sof=%0b eof=%0b expected sof=%0b eof=%0b",
                 i, q_sof[i], q_eof[i], (i % N == 0), (i % N == N - 1));
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int k = 0; k < N; k++) drive(40 + br[k], -(40 + br[k]), 1'b1);
    for (int k = 0; k < 5; k++) drive(200 + br[k], -(200 + br[k]), 1'b1);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    din_valid = 1'b0;
    // frame 1 had emitted bins 0..3 when the reset hit
    checks++;
    if (q_re.size() !== 4) begin
      failures++;
      $display("FAIL midrst partial count: got %0d expected 4", q_re.size());
    end else begin
      checks++;
      if (q_re[0] !== 16'sd40 || q_re[3] !== 16'sd43) begin
        failures++;
        $display("FAIL midrst partial data: got %0d,%0d expected 40,43", q_re[0], q_re[3]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_re !== '0) begin
      failures++;
      $display("FAIL midrst valid: got valid=%0b re=%0d expected 0 0", dout_valid, dout_re);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < N; k++) drive(100 + br[k], -(100 + br[k]), 1'b1);
    idle(14);
    check_frames("after_rst", 100, N, t_last);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
